// File: rtl/comp_share_arbiter_pkg.sv
// Shared definitions for the comparator-sharing arbiter: FSM encoding and the
// operand width fixed by the four_bit_comp datapath.
package comp_share_arbiter_pkg;

  localparam int CMP_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/comp_share_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request scanning
// ptr, ptr+1, ... modulo N.
module comp_share_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    // Scan from farthest to nearest so the closest request to ptr wins last.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/four_bit_comp.sv
// Unsigned 4-bit magnitude comparator; exactly one of e/l/g is high.
module four_bit_comp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       e,
  output logic       l,
  output logic       g
);

  assign e = (a == b);
  assign l = (a < b);
  assign g = (a > b);

endmodule

// File: rtl/comp_share_arbiter.sv
// Round-robin arbiter sharing one four_bit_comp between NUM_REQ requesters;
// results return with the owner's index over a valid/ready channel.
module comp_share_arbiter
  import comp_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = CMP_WIDTH,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_e,
  output logic                     rsp_l,
  output logic                     rsp_g
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_e_q, rsp_e_d;
  logic              rsp_l_q, rsp_l_d;
  logic              rsp_g_q, rsp_g_d;

  logic [WIDTH-1:0]  a_arr [NUM_REQ];
  logic [WIDTH-1:0]  b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic              cmp_e, cmp_l, cmp_g;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  comp_share_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  four_bit_comp u_comp (
    .a (op_a_q),
    .b (op_b_q),
    .e (cmp_e),
    .l (cmp_l),
    .g (cmp_g)
  );

  // Grant is offered only in IDLE, so an accept never overlaps a pending result.
  assign req_ready = (state_q == ST_IDLE && !rst) ? pick_grant : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_e_d     = rsp_e_q;
    rsp_l_d     = rsp_l_q;
    rsp_g_d     = rsp_g_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          op_a_d     = a_arr[pick_idx];
          op_b_d     = b_arr[pick_idx];
          grant_id_d = pick_idx;
          state_d    = ST_CMP;
        end
      end
      ST_CMP: begin
        rsp_e_d     = cmp_e;
        rsp_l_d     = cmp_l;
        rsp_g_d     = cmp_g;
        rsp_id_d    = grant_id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_e_q     <= 1'b0;
      rsp_l_q     <= 1'b0;
      rsp_g_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_e_q     <= rsp_e_d;
      rsp_l_q     <= rsp_l_d;
      rsp_g_q     <= rsp_g_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_e     = rsp_e_q;
  assign rsp_l     = rsp_l_q;
  assign rsp_g     = rsp_g_q;

endmodule

// File: tb/tb_comp_share_arbiter.sv
// Scoreboard bench for comp_share_arbiter: directed requests push expected
// grants/responses; a negedge monitor checks every response handshake.
module tb_comp_share_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic       e;
    logic       l;
    logic       g;
  } exp_t;

  localparam logic [2:0] R_E = 3'b100;
  localparam logic [2:0] R_L = 3'b010;
  localparam logic [2:0] R_G = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_e, rsp_l, rsp_g;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t       exp_q[$];
  logic [3:0] grant_q[$];

  comp_share_arbiter #(.NUM_REQ(4), .WIDTH(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_e     (rsp_e),
    .rsp_l     (rsp_l),
    .rsp_g     (rsp_g)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  task automatic push_rsp(input logic [1:0] id, input logic [2:0] r);
    exp_t x;
    x.id = id;
    {x.e, x.l, x.g} = r;
    exp_q.push_back(x);
  endtask

  // Wait for n accepts, checking each grant; then drop requests and scramble operands.
  task automatic accept_n(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if ((req_valid & req_ready) != 4'b0000) begin
        chk("grant", 32'(req_ready), 32'(grant_q.pop_front()));
        got++;
        if (got == n) begin
          @(posedge clk);
          #1;
          req_valid = 4'b0000;
          req_a     = 16'hFFFF;
          req_b     = 16'h0000;
        end
      end
    end
    if (got < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got %0d accepts expected %0d", got, n);
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      chk("rsp_onehot", 32'({rsp_e, rsp_l, rsp_g} == R_E || {rsp_e, rsp_l, rsp_g} == R_L ||
                            {rsp_e, rsp_l, rsp_g} == R_G), 32'd1);
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: id=%0d elg=%b expected none", rsp_id, {rsp_e, rsp_l, rsp_g});
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("rsp", 32'({rsp_id, rsp_e, rsp_l, rsp_g}), 32'(x));
          $display("rsp id=%0d e=%b l=%b g=%b", rsp_id, rsp_e, rsp_l, rsp_g);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp", 32'({rsp_valid, rsp_id, rsp_e, rsp_l, rsp_g}), 32'd0);
    req_valid = 4'b0000;
    rst       = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd0);

    // Single request from requester 0, then latency of two cycles.
    @(posedge clk); #1;
    set_op(0, 4'b0110, 4'b1101);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    grant_q.push_back(4'b0001);
    push_rsp(2'd0, R_L);
    accept_n(1);
    @(negedge clk);
    chk("latency_cycle1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("latency_cycle2_valid", 32'(rsp_valid), 32'd1);
    chk("latency_cycle2_id", 32'(rsp_id), 32'd0);
    @(posedge clk); #1;

    // rr_ptr is now 1: requester 1 beats requester 0.
    set_op(0, 4'b0001, 4'b0010);
    set_op(1, 4'b0111, 4'b0111);
    req_valid = 4'b0011;
    grant_q.push_back(4'b0010);
    push_rsp(2'd1, R_E);
    accept_n(1);
    drain();

    // Backpressure on requester 2; requesters 0 and 3 wait during the stall.
    rsp_ready = 1'b0;
    set_op(2, 4'b1110, 4'b1001);
    req_valid = 4'b0100;
    grant_q.push_back(4'b0100);
    push_rsp(2'd2, R_G);
    accept_n(1);
    begin
      int cyc = 0;
      while (!rsp_valid && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      chk("bp_rsp_arrived", 32'(rsp_valid), 32'd1);
    end
    @(posedge clk); #1;
    set_op(0, 4'b0101, 4'b0010);
    set_op(3, 4'b0011, 4'b0011);
    req_valid = 4'b1001;
    grant_q.push_back(4'b1000);
    grant_q.push_back(4'b0001);
    push_rsp(2'd3, R_E);
    push_rsp(2'd0, R_G);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_g", 32'({rsp_e, rsp_l, rsp_g}), 32'(R_G));
      chk("bp_id", 32'(rsp_id), 32'd2);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    accept_n(2);
    drain();

    // Reset while the comparison is in flight discards it.
    set_op(1, 4'b1001, 4'b0001);
    req_valid = 4'b0010;
    grant_q.push_back(4'b0010);
    accept_n(1);
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk("midrst_rsp", 32'({rsp_valid, rsp_id, rsp_e, rsp_l, rsp_g}), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;

    // All four requesting continuously from rr_ptr 0.
    set_op(0, 4'b0000, 4'b0001);
    set_op(1, 4'b0001, 4'b0001);
    set_op(2, 4'b1100, 4'b0111);
    set_op(3, 4'b1111, 4'b1111);
    req_valid = 4'b1111;
    grant_q.push_back(4'b0001);
    grant_q.push_back(4'b0010);
    grant_q.push_back(4'b0100);
    grant_q.push_back(4'b1000);
    grant_q.push_back(4'b0001);
    push_rsp(2'd0, R_L);
    push_rsp(2'd1, R_E);
    push_rsp(2'd2, R_G);
    push_rsp(2'd3, R_E);
    push_rsp(2'd0, R_L);
    accept_n(5);
    drain();

    // Operands change right after accept; result follows the captured pair.
    set_op(2, 4'b0100, 4'b0101);
    req_valid = 4'b0100;
    grant_q.push_back(4'b0100);
    push_rsp(2'd2, R_L);
    accept_n(1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
